// File: rtl/tree_pkg.sv
// Shared types and default sizing for the field-id tree encoder.
// The encoder turns depth-tagged nodes into a balanced open/close token stream.
package tree_pkg;

  localparam int ENC_ID_W      = 8;
  localparam int ENC_MAX_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLOSE,
    ST_OPEN,
    ST_DRAIN,
    ST_DONE
  } enc_state_t;

endpackage

// File: rtl/id_stack.sv
// LIFO of currently open field ids.
// Exposes the top entry and the entry below it so the encoder can preload the next close token.
module id_stack #(
  parameter int ID_W  = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [ID_W-1:0]  push_id_i,
  output logic [ID_W-1:0]  top_o,
  output logic [ID_W-1:0]  under_o,
  output logic [CNT_W-1:0] count_o
);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [ID_W-1:0]  mem_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Push is ignored when full and pop when empty, so the count never wraps.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push_i && (count_q != CNT_W'(DEPTH))) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == count_q) begin
          mem_d[i] = push_id_i;
        end
      end
      count_d = count_q + CNT_W'(1);
    end else if (pop_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    top_o   = '0;
    under_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i + 1) == count_q) begin
        top_o = mem_q[i];
      end
      if (CNT_W'(i + 2) == count_q) begin
        under_o = mem_q[i];
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/field_id_encoder.sv
// Converts a stream of (field id, depth, last) node descriptors into open/close tokens.
// Every output is a register; the next token is preloaded on each completed beat for full throughput.
module field_id_encoder
  import tree_pkg::*;
#(
  parameter int ID_W      = ENC_ID_W,
  parameter int MAX_DEPTH = ENC_MAX_DEPTH,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               node_valid,
  output logic               node_rdy,
  input  logic [ID_W-1:0]    node_field_id,
  input  logic [DEPTH_W-1:0] node_depth,
  input  logic               node_last,
  output logic [ID_W-1:0]    field_id_o,
  output logic               field_id_close,
  output logic               field_id_valid,
  input  logic               field_id_rdy,
  output logic               msg_done,
  output logic               err_o
);

  localparam logic [DEPTH_W-1:0] MAX_LVL = DEPTH_W'(MAX_DEPTH);

  enc_state_t         state_q, state_d;
  logic [ID_W-1:0]    tok_id_q, tok_id_d;
  logic               tok_close_q, tok_close_d;
  logic               tok_valid_q, tok_valid_d;
  logic               msg_done_q, msg_done_d;
  logic               err_q, err_d;
  logic               node_rdy_q, node_rdy_d;
  logic [ID_W-1:0]    lat_id_q, lat_id_d;
  logic [DEPTH_W-1:0] lat_depth_q, lat_depth_d;
  logic               lat_last_q, lat_last_d;

  logic               push;
  logic               pop;
  logic               beat;
  logic [ID_W-1:0]    top_id;
  logic [ID_W-1:0]    under_id;
  logic [DEPTH_W-1:0] sp;
  logic [DEPTH_W-1:0] sp_dec;

  id_stack #(
    .ID_W  (ID_W),
    .DEPTH (MAX_DEPTH),
    .CNT_W (DEPTH_W)
  ) u_stack (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_i    (push),
    .pop_i     (pop),
    .push_id_i (lat_id_q),
    .top_o     (top_id),
    .under_o   (under_id),
    .count_o   (sp)
  );

  assign beat   = tok_valid_q && field_id_rdy;
  assign sp_dec = sp - DEPTH_W'(1);

  // The token registers only change when no token is pending or a beat completes,
  // which keeps a stalled token stable without extra holding logic.
  always_comb begin
    state_d     = state_q;
    tok_id_d    = tok_id_q;
    tok_close_d = tok_close_q;
    tok_valid_d = tok_valid_q;
    msg_done_d  = 1'b0;
    err_d       = err_q;
    lat_id_d    = lat_id_q;
    lat_depth_d = lat_depth_q;
    lat_last_d  = lat_last_q;
    push        = 1'b0;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (node_valid) begin
          if ((node_depth > sp) || (node_depth == MAX_LVL)) begin
            err_d = 1'b1;
          end else begin
            lat_id_d    = node_field_id;
            lat_depth_d = node_depth;
            lat_last_d  = node_last;
            tok_valid_d = 1'b1;
            if (node_depth < sp) begin
              state_d     = ST_CLOSE;
              tok_id_d    = top_id;
              tok_close_d = 1'b1;
            end else begin
              state_d     = ST_OPEN;
              tok_id_d    = node_field_id;
              tok_close_d = 1'b0;
            end
          end
        end
      end

      ST_CLOSE: begin
        if (beat) begin
          pop = 1'b1;
          if (sp_dec == lat_depth_q) begin
            state_d     = ST_OPEN;
            tok_id_d    = lat_id_q;
            tok_close_d = 1'b0;
          end else begin
            tok_id_d    = under_id;
            tok_close_d = 1'b1;
          end
        end
      end

      ST_OPEN: begin
        if (beat) begin
          push = 1'b1;
          if (lat_last_q) begin
            // The id just pushed becomes the first close of the drain.
            state_d     = ST_DRAIN;
            tok_id_d    = lat_id_q;
            tok_close_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            tok_valid_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (beat) begin
          pop = 1'b1;
          if (sp_dec == '0) begin
            state_d     = ST_DONE;
            tok_valid_d = 1'b0;
            msg_done_d  = 1'b1;
          end else begin
            tok_id_d    = under_id;
            tok_close_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        tok_valid_d = 1'b0;
      end
    endcase

    node_rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      tok_id_q    <= '0;
      tok_close_q <= 1'b0;
      tok_valid_q <= 1'b0;
      msg_done_q  <= 1'b0;
      err_q       <= 1'b0;
      node_rdy_q  <= 1'b1;
      lat_id_q    <= '0;
      lat_depth_q <= '0;
      lat_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tok_id_q    <= tok_id_d;
      tok_close_q <= tok_close_d;
      tok_valid_q <= tok_valid_d;
      msg_done_q  <= msg_done_d;
      err_q       <= err_d;
      node_rdy_q  <= node_rdy_d;
      lat_id_q    <= lat_id_d;
      lat_depth_q <= lat_depth_d;
      lat_last_q  <= lat_last_d;
    end
  end

  assign node_rdy       = node_rdy_q;
  assign field_id_o     = tok_id_q;
  assign field_id_close = tok_close_q;
  assign field_id_valid = tok_valid_q;
  assign msg_done       = msg_done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_field_id_encoder.sv
// Scoreboard bench for field_id_encoder: a reference stack model queues expected tokens as
// descriptors are driven, and a negedge monitor pops and compares them as the DUT emits.
module tb_field_id_encoder;

  localparam int ID_W      = 8;
  localparam int MAX_DEPTH = 8;
  localparam int DEPTH_W   = 4;
  localparam int BUDGET    = 2000;

  logic               clk_i = 1'b0;
  logic               reset_i = 1'b0;
  logic               node_valid = 1'b0;
  logic               node_rdy;
  logic [ID_W-1:0]    node_field_id = '0;
  logic [DEPTH_W-1:0] node_depth = '0;
  logic               node_last = 1'b0;
  logic [ID_W-1:0]    field_id_o;
  logic               field_id_close;
  logic               field_id_valid;
  logic               field_id_rdy = 1'b1;
  logic               msg_done;
  logic               err_o;

  logic [9:0]         exp_q [$];
  logic [ID_W-1:0]    model_stk [$];
  int                 checks = 0;
  int                 errors = 0;
  int                 rdy_mode = 0;
  logic               manual_rdy = 1'b0;
  int                 opens = 0;
  int                 closes = 0;
  int                 nodes_sent = 0;
  logic               stall_prev = 1'b0;
  logic [9:0]         held_tok = '0;

  always #5 clk_i = ~clk_i;

  field_id_encoder #(
    .ID_W      (ID_W),
    .MAX_DEPTH (MAX_DEPTH),
    .DEPTH_W   (DEPTH_W)
  ) u_dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .node_valid     (node_valid),
    .node_rdy       (node_rdy),
    .node_field_id  (node_field_id),
    .node_depth     (node_depth),
    .node_last      (node_last),
    .field_id_o     (field_id_o),
    .field_id_close (field_id_close),
    .field_id_valid (field_id_valid),
    .field_id_rdy   (field_id_rdy),
    .msg_done       (msg_done),
    .err_o          (err_o)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Token encoding: {kind, id} with kind 0 = open, 1 = close, 2 = msg_done.
  task automatic send_node(input logic [ID_W-1:0] id, input int depth, input bit last);
    int cyc;
    if (!((depth > model_stk.size()) || (depth == MAX_DEPTH))) begin
      while (model_stk.size() > depth) begin
        exp_q.push_back({2'b01, model_stk[$]});
        void'(model_stk.pop_back());
      end
      exp_q.push_back({2'b00, id});
      model_stk.push_back(id);
      if (last) begin
        while (model_stk.size() > 0) begin
          exp_q.push_back({2'b01, model_stk[$]});
          void'(model_stk.pop_back());
        end
        exp_q.push_back({2'b10, 8'h00});
      end
    end
    node_valid    = 1'b1;
    node_field_id = id;
    node_depth    = DEPTH_W'(depth);
    node_last     = last;
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!node_rdy && (cyc < BUDGET));
    if (!node_rdy) begin
      check_output("accept_timeout", 32'(node_rdy), 32'd1);
    end
    @(posedge clk_i);
    #1;
    node_valid = 1'b0;
    node_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!((exp_q.size() == 0) && node_rdy && !field_id_valid && !msg_done) && (cyc < BUDGET));
    if (cyc >= BUDGET) begin
      check_output("idle_timeout", 32'(exp_q.size()), 32'd0);
    end
    tick();
  endtask

  task automatic do_reset();
    reset_i    = 1'b1;
    node_valid = 1'b0;
    exp_q.delete();
    model_stk.delete();
    #1;
    check_output("rst_valid", 32'(field_id_valid), 32'd0);
    check_output("rst_id", 32'(field_id_o), 32'd0);
    check_output("rst_close", 32'(field_id_close), 32'd0);
    check_output("rst_done", 32'(msg_done), 32'd0);
    check_output("rst_err", 32'(err_o), 32'd0);
    check_output("rst_sp", 32'(u_dut.sp), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    check_output("rst_node_rdy", 32'(node_rdy), 32'd1);
  endtask

  // Ready driver: the mode is captured on the clock edge and applied 1 time unit later.
  initial begin
    int   mode;
    logic man;
    forever begin
      @(posedge clk_i);
      mode = rdy_mode;
      man  = manual_rdy;
      #1;
      case (mode)
        0:       field_id_rdy = 1'b1;
        1:       field_id_rdy = ($urandom_range(0, 9) < 7);
        2:       field_id_rdy = 1'b0;
        default: field_id_rdy = man;
      endcase
    end
  end

  // Monitor: compares completed beats and msg_done pulses, and checks stalled tokens hold.
  initial begin
    logic [9:0] obs;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_output("hold", 32'({field_id_valid, field_id_close, field_id_o}), 32'(held_tok));
        end
        if (field_id_valid && field_id_rdy) begin
          obs = {1'b0, field_id_close, field_id_o};
          if (field_id_close) closes++;
          else opens++;
          if (exp_q.size() == 0) check_output("extra_token", 32'(obs), 32'h3FF);
          else check_output("token", 32'(obs), 32'(exp_q.pop_front()));
        end
        if (msg_done) begin
          obs = {2'b10, 8'h00};
          if (exp_q.size() == 0) check_output("extra_done", 32'(obs), 32'h3FF);
          else check_output("done", 32'(obs), 32'(exp_q.pop_front()));
        end
        stall_prev = field_id_valid && !field_id_rdy;
        held_tok   = {field_id_valid, field_id_close, field_id_o};
      end
    end
  end

  initial begin
    int n;
    int lim;
    int depth;
    do_reset();

    // Nested message with continuous ready.
    send_node(8'd5, 0, 1'b0);
    send_node(8'd7, 1, 1'b0);
    send_node(8'd9, 1, 1'b1);
    wait_idle();

    // Single-node message with the open token stalled for four cycles.
    rdy_mode = 2;
    tick();
    tick();
    send_node(8'd3, 0, 1'b1);
    repeat (4) begin
      @(negedge clk_i);
      check_output("stall_valid", 32'(field_id_valid), 32'd1);
      check_output("stall_tok", 32'({field_id_close, field_id_o}), 32'({1'b0, 8'd3}));
    end
    tick();
    rdy_mode = 0;
    wait_idle();

    // Depth jump beyond the stack is rejected without disturbing it.
    send_node(8'd10, 0, 1'b0);
    wait_idle();
    send_node(8'd4, 3, 1'b0);
    wait_idle();
    check_output("jump_err", 32'(err_o), 32'd1);
    check_output("jump_sp", 32'(u_dut.sp), 32'(model_stk.size()));
    send_node(8'd6, 1, 1'b0);
    wait_idle();
    check_output("after_err_sp", 32'(u_dut.sp), 32'(model_stk.size()));
    do_reset();

    // Full stack, overflow attempt, then a top-level last node drains everything.
    for (int i = 0; i < MAX_DEPTH; i++) begin
      send_node(ID_W'(i + 1), i, 1'b0);
    end
    wait_idle();
    check_output("full_err", 32'(err_o), 32'd0);
    check_output("full_sp", 32'(u_dut.sp), 32'd8);
    send_node(8'd20, MAX_DEPTH, 1'b0);
    wait_idle();
    check_output("ovf_err", 32'(err_o), 32'd1);
    check_output("ovf_sp", 32'(u_dut.sp), 32'd8);
    send_node(8'd21, 0, 1'b1);
    wait_idle();
    check_output("drain_sp", 32'(u_dut.sp), 32'd0);
    do_reset();

    // Reset while draining three open levels.
    send_node(8'd1, 0, 1'b0);
    send_node(8'd2, 1, 1'b0);
    wait_idle();
    rdy_mode = 2;
    tick();
    tick();
    send_node(8'd3, 2, 1'b1);
    rdy_mode   = 3;
    manual_rdy = 1'b1;
    tick();
    manual_rdy = 1'b0;
    tick();
    @(negedge clk_i);
    check_output("drain_valid", 32'(field_id_valid), 32'd1);
    check_output("drain_tok", 32'({field_id_close, field_id_o}), 32'({1'b1, 8'd3}));
    check_output("drain_sp3", 32'(u_dut.sp), 32'd3);
    do_reset();
    rdy_mode = 0;
    send_node(8'd2, 0, 1'b1);
    wait_idle();

    // Random legal messages under random back-pressure.
    do_reset();
    rdy_mode   = 1;
    opens      = 0;
    closes     = 0;
    nodes_sent = 0;
    for (int m = 0; m < 1000; m++) begin
      n = int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++) begin
        lim = model_stk.size();
        if (lim > MAX_DEPTH - 1) lim = MAX_DEPTH - 1;
        depth = (k == 0) ? 0 : int'($urandom_range(0, lim));
        send_node(ID_W'($urandom_range(0, 255)), depth, (k == n - 1));
        nodes_sent++;
      end
    end
    rdy_mode = 0;
    wait_idle();
    check_output("rand_opens", 32'(opens), 32'(nodes_sent));
    check_output("rand_closes", 32'(closes), 32'(nodes_sent));
    check_output("rand_err", 32'(err_o), 32'd0);
    check_output("rand_sp", 32'(u_dut.sp), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/field_id_encoder.md
FIELD_ID_ENCODER -- requirements
Module: field_id_encoder

Interface
REQ-001 Parameter ID_W, default 8, width of a field identifier.
REQ-002 Parameter MAX_DEPTH, default 8, maximum open nesting levels; DEPTH_W = $clog2(MAX_DEPTH+1).
REQ-003 clk_i  input  1  sole clock; all state on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 node_valid  input  1  node descriptor present.
REQ-006 node_rdy  output  1  encoder accepts descriptor this cycle.
REQ-007 node_field_id  input  ID_W  field identifier of node.
REQ-008 node_depth  input  DEPTH_W  nesting level of node (0 = top level).
REQ-009 node_last  input  1  node is final node of message.
REQ-010 field_id_o  output  ID_W  emitted identifier token.
REQ-011 field_id_close  output  1  token is a close-of-group marker (1) or an open (0).
REQ-012 field_id_valid  output  1  token valid.
REQ-013 field_id_rdy  input  1  downstream accepts token.
REQ-014 msg_done  output  1  one-cycle pulse after final close of a message.
REQ-015 err_o  output  1  sticky protocol error flag.

Function
REQ-016 Encoder SHALL hold a LIFO of open field ids; sp = occupancy (0..MAX_DEPTH).
REQ-017 FSM states SHALL be IDLE, CLOSE, OPEN, DRAIN, DONE.
REQ-018 node_rdy SHALL be 1 only in IDLE; descriptor accepted when node_valid && node_rdy.
REQ-019 Accept with node_depth > sp, or node_depth == MAX_DEPTH: err_o <= 1, descriptor dropped, no token, stay IDLE.
REQ-020 Valid accept with node_depth < sp: latch descriptor, go CLOSE; each CLOSE beat pops top and emits it with field_id_close=1 until sp == node_depth, then go OPEN.
REQ-021 Valid accept with node_depth == sp: go directly OPEN; open token valid cycle after acceptance.
REQ-022 OPEN SHALL emit latched id with field_id_close=0 and push it; then IDLE, or DRAIN if latched node_last.
REQ-023 DRAIN SHALL pop and emit close tokens until sp == 0, then DONE.
REQ-024 DONE SHALL assert msg_done for exactly one cycle and return to IDLE.
REQ-025 A token beat completes (pop/push/advance) only on field_id_valid && field_id_rdy.
REQ-026 While field_id_valid && !field_id_rdy, field_id_o, field_id_close, field_id_valid SHALL hold stable.
REQ-027 All outputs registered; no combinational path from field_id_rdy or node_valid to any output.
REQ-028 Throughput: one token per cycle under continuous field_id_rdy; no idle bubble between consecutive CLOSE/OPEN/DRAIN beats.
REQ-029 err_o SHALL not block subsequent valid descriptors.

Reset
REQ-030 On reset_i: state IDLE, sp=0, field_id_valid=0, field_id_o=0, field_id_close=0, msg_done=0, err_o=0; node_rdy=1 after deassertion.
REQ-031 Reset mid-message SHALL discard stack and any pending token without emitting closes.

Structure
REQ-032 enc_state_t enum, ENC_ID_W and ENC_MAX_DEPTH default constants SHALL live in tree_pkg.
REQ-033 LIFO SHALL be sub-module id_stack (push, pop, top, count; async reset); remainder in field_id_encoder.

Verification
REQ-034 Nodes (5,d0),(7,d1),(9,d1,last), rdy=1 -> tokens open5, open7, close7, open9, close9, close5, msg_done once.
REQ-035 Node (3,d0,last) with field_id_rdy low 4 cycles -> open3 held stable 4 cycles, then close3, msg_done.
REQ-036 Open depths 0..7 (ids 1..8), then (20,d8) -> err_o=1, no token, sp stays 8; then (21,d0,last) -> closes 8..1, open21, close21, msg_done.
REQ-037 With sp=1, node (4,d3) -> err_o=1, nothing emitted; next node (6,d1) -> open6 normally.
REQ-038 Reset asserted in DRAIN with sp=3 -> field_id_valid=0 immediately, sp=0; next (2,d0,last) -> open2, close2, msg_done.
REQ-039 Random rdy back-pressure, 1000 random legal messages -> token stream matches scoreboard, balanced opens/closes, err_o=0.
